greater_than: RTL and testbench

//   Unsigned magnitude comparator: o_ab = 1 when i_a > i_b. A combinational result

---
 rtl/greater_than_pkg.sv | 39 +++
 rtl/gt_tree_node.sv | 12 +
 rtl/greater_than.sv | 95 +++++++++
 tb/tb_greater_than.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/greater_than_pkg.sv
// Shared compare-cell type, merge function and tree sizing helpers for greater_than.
package greater_than_pkg;

    typedef struct packed {
        logic gt;
        logic eq;
    } cmp_t;

    // hi covers the more significant bits, so it decides unless it is equal.
    function automatic cmp_t cmp_merge(input cmp_t hi, input cmp_t lo);
        cmp_t r;
        r.gt = hi.gt | (hi.eq & lo.gt);
        r.eq = hi.eq & lo.eq;
        return r;
    endfunction

    // Node count on a given tree level; level 0 holds one leaf per bit.
    function automatic int unsigned level_nodes(input int unsigned width,
                                                input int unsigned level);
        int unsigned n;
        n = width;
        for (int unsigned k = 0; k < level; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Index of the first node of a level in the flattened node array.
    function automatic int unsigned level_offset(input int unsigned width,
                                                 input int unsigned level);
        int unsigned off;
        off = 0;
        for (int unsigned k = 0; k < level; k++) begin
            off += level_nodes(width, k);
        end
        return off;
    endfunction

endpackage

// File: rtl/gt_tree_node.sv
// One inner node of the comparator tree: merges a high and a low (gt,eq) pair.
module gt_tree_node
    import greater_than_pkg::*;
(
    input  cmp_t hi_i,
    input  cmp_t lo_i,
    output cmp_t merged_o
);

    assign merged_o = cmp_merge(hi_i, lo_i);

endmodule

// File: rtl/greater_than.sv
// Magnitude comparator: combinational o_ab plus registered gt/eq/lt with valid.
// Optional GREATER_THAN_SIGNED_EN adds i_signed for two's-complement compares.
module greater_than
    import greater_than_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef GREATER_THAN_SIGNED_EN
    input  logic             i_signed,
`endif
    output logic             o_ab,
    output logic             o_valid,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned NODES  = level_offset(WIDTH, LEVELS) + 1;

    logic signed_mode;
`ifdef GREATER_THAN_SIGNED_EN
    assign signed_mode = i_signed;
`else
    assign signed_mode = 1'b0;
`endif

    // Flattened tree: level 0 leaves first, root is the last element.
    cmp_t tree [NODES];

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_leaf
        logic leaf_gt;
        if (i == int'(WIDTH) - 1) begin : g_msb
            // A set sign bit means the smaller operand in two's complement.
            assign leaf_gt = signed_mode ? (~i_a[i] & i_b[i]) : (i_a[i] & ~i_b[i]);
        end else begin : g_low
            assign leaf_gt = i_a[i] & ~i_b[i];
        end
        assign tree[i] = {leaf_gt, ~(i_a[i] ^ i_b[i])};
    end

    for (genvar l = 1; l <= int'(LEVELS); l++) begin : g_level
        localparam int SRC   = int'(level_offset(WIDTH, l - 1));
        localparam int DST   = int'(level_offset(WIDTH, l));
        localparam int N_SRC = int'(level_nodes(WIDTH, l - 1));

        for (genvar j = 0; j < N_SRC / 2; j++) begin : g_pair
            gt_tree_node u_node (
                .hi_i     (tree[SRC + 2*j + 1]),
                .lo_i     (tree[SRC + 2*j]),
                .merged_o (tree[DST + j])
            );
        end

        if (N_SRC % 2 == 1) begin : g_pass
            assign tree[DST + N_SRC/2] = tree[SRC + N_SRC - 1];
        end
    end

    cmp_t root;
    logic root_lt;

    assign root    = tree[NODES-1];
    assign root_lt = ~root.gt & ~root.eq;
    assign o_ab    = root.gt;

    logic valid_q, gt_q, eq_q, lt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                gt_q <= root.gt;
                eq_q <= root.eq;
                lt_q <= root_lt;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_gt    = gt_q;
    assign o_eq    = eq_q;
    assign o_lt    = lt_q;

endmodule

// File: tb/tb_greater_than.sv
// Randomized self-checking bench: WIDTH 4, 5 and 1 comparators against an arithmetic model.
module tb_greater_than;

`ifdef GREATER_THAN_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, sgn;
    logic [3:0] a4, b4;
    logic [4:0] a5, b5;
    logic       a1, b1;
    logic       ab4, v4, gt4, eq4, lt4;
    logic       ab5, v5, gt5, eq5, lt5;
    logic       ab1, v1, gt1, eq1, lt1;

    int n_checks = 0;
    int n_errors = 0;

    // Expected registered state per instance: {valid, gt, eq, lt}.
    logic [3:0] exp4, exp5, exp1;

    greater_than #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_a(a4), .i_b(b4),
`ifdef GREATER_THAN_SIGNED_EN
        .i_signed(sgn),
`endif
        .o_ab(ab4), .o_valid(v4), .o_gt(gt4), .o_eq(eq4), .o_lt(lt4)
    );

    greater_than #(.WIDTH(5)) u_dut5 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_a(a5), .i_b(b5),
`ifdef GREATER_THAN_SIGNED_EN
        .i_signed(sgn),
`endif
        .o_ab(ab5), .o_valid(v5), .o_gt(gt5), .o_eq(eq5), .o_lt(lt5)
    );

    greater_than #(.WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_a(a1), .i_b(b1),
`ifdef GREATER_THAN_SIGNED_EN
        .i_signed(sgn),
`endif
        .o_ab(ab1), .o_valid(v1), .o_gt(gt1), .o_eq(eq1), .o_lt(lt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {gt, eq, lt} from the numeric values of the operands.
    function automatic logic [2:0] ref_cmp(input longint a, input longint b, input int w,
                                           input logic s);
        longint one;
        longint sa;
        longint sb;
        one = 1;
        sa  = a;
        sb  = b;
        if (s) begin
            if (a >= (one << (w - 1))) sa = a - (one << w);
            if (b >= (one << (w - 1))) sb = b - (one << w);
        end
        if (sa > sb) return 3'b100;
        if (sa == sb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check_regs();
        check("reg_w4", 32'({v4, gt4, eq4, lt4}), 32'(exp4));
        check("reg_w5", 32'({v5, gt5, eq5, lt5}), 32'(exp5));
        check("reg_w1", 32'({v1, gt1, eq1, lt1}), 32'(exp1));
        if (v4) check("onehot_w4", 32'($countones({gt4, eq4, lt4})), 32'd1);
        if (v5) check("onehot_w5", 32'($countones({gt5, eq5, lt5})), 32'd1);
        if (v1) check("onehot_w1", 32'($countones({gt1, eq1, lt1})), 32'd1);
    endtask

    // Drives one cycle of operands, checks o_ab, then checks the registers after the edge.
    task automatic cycle(input logic v, input logic s, input logic [3:0] xa4,
                         input logic [3:0] xb4, input logic [4:0] xa5, input logic [4:0] xb5,
                         input logic xa1, input logic xb1);
        logic [2:0] r4, r5, r1;
        valid = v;
        sgn   = s & SIGNED_EN;
        a4 = xa4; b4 = xb4; a5 = xa5; b5 = xb5; a1 = xa1; b1 = xb1;
        r4 = ref_cmp(longint'(xa4), longint'(xb4), 4, sgn);
        r5 = ref_cmp(longint'(xa5), longint'(xb5), 5, sgn);
        r1 = ref_cmp(longint'(xa1), longint'(xb1), 1, sgn);
        #1;
        check("ab_w4", 32'(ab4), 32'(r4[2]));
        check("ab_w5", 32'(ab5), 32'(r5[2]));
        check("ab_w1", 32'(ab1), 32'(r1[2]));
        exp4 = v ? {1'b1, r4} : {1'b0, exp4[2:0]};
        exp5 = v ? {1'b1, r5} : {1'b0, exp5[2:0]};
        exp1 = v ? {1'b1, r1} : {1'b0, exp1[2:0]};
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sgn = 1'b0;
        a4 = '0; b4 = '0; a5 = '0; b5 = '0; a1 = 1'b0; b1 = 1'b0;
        exp4 = '0; exp5 = '0; exp1 = '0;
        #12;
        check_regs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'b1000, 4'b0111, 5'b10000, 5'b01111, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'b1111, 4'b1110, 5'b11111, 5'b11111, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 4'b0010, 4'b0100, 5'($urandom), 5'($urandom), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 4'b0001, 4'b0010, 5'($urandom), 5'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'b1111, 4'b1111, 5'($urandom), 5'($urandom), 1'b1, 1'b0);

        // Hold: registered results must stay while o_valid drops.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 4'($urandom), 4'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom));
        end

        cycle(1'b1, 1'b1, 4'b1000, 4'b0111, 5'b10000, 5'b01111, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'b1000, 4'b0111, 5'b10000, 5'b01111, 1'b1, 1'b0);

        // Asynchronous reset between edges clears the registers without a clock.
        cycle(1'b1, 1'b0, 4'b1001, 4'b0011, 5'd7, 5'd9, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp4 = '0; exp5 = '0; exp1 = '0;
        check_regs();
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 4'b0011, 4'b0011, 5'd3, 5'd2, 1'b0, 1'b1);

        // Exhaustive WIDTH=5 and WIDTH=1 sweeps, random WIDTH=4 and random valid.
        for (int sp = 0; sp <= int'(SIGNED_EN); sp++) begin
            for (int i = 0; i < 1024; i++) begin
                cycle(($urandom % 4) != 0, sp[0], 4'($urandom), 4'($urandom),
                      i[9:5], i[4:0], i[0], i[1]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
